// File: rtl/mem_window_pkg.sv
// mem_window_pkg: shared definitions for the mem_window memory window.
//   - legal bus ack latencies (LAT_MIN / LAT_MAX)
//   - mw_clog2(): constant ceil(log2) helper used to size offset fields
//   - `MEM_WINDOW_LANES(dw): byte-lane count for a data width
// Optional feature macro used by the window: MEM_WINDOW_FWD_EN (see mem_window.sv).

`ifndef MEM_WINDOW_LANES
`define MEM_WINDOW_LANES(dw) ((dw) / 8)
`endif

package mem_window_pkg;

  localparam int unsigned LAT_MIN = 1;
  localparam int unsigned LAT_MAX = 2;

  function automatic int unsigned mw_clog2(input longint unsigned v);
    longint unsigned x;
    int unsigned     r;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_window_ram.sv
// mem_window_ram: inferred true-dual-port RAM, single clock, no reset.
//   Port A: byte-lane write or synchronous read (one per cycle).
//   Port B: synchronous read-only; output holds while b_en=0.
// A same-cycle A-write / B-read of one word returns the old word on port B.
// Ports:
//   clk                         clock, rising edge
//   a_en, a_we, a_sel, a_addr   port A enable, write select, lane enables, word offset
//   a_wdata / a_rdata           port A write / registered read data
//   b_en, b_addr / b_rdata      port B enable, word offset / registered read data

module mem_window_ram
  import mem_window_pkg::*;
#(
  parameter  int unsigned SIZE = 1024,
  parameter  int unsigned DW   = 32,
  localparam int unsigned OW   = mw_clog2(SIZE),
  localparam int unsigned NL   = `MEM_WINDOW_LANES(DW)
) (
  input  logic          clk,
  input  logic          a_en,
  input  logic          a_we,
  input  logic [NL-1:0] a_sel,
  input  logic [OW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic [DW-1:0] a_rdata,
  input  logic          b_en,
  input  logic [OW-1:0] b_addr,
  output logic [DW-1:0] b_rdata
);

  logic [DW-1:0] mem [SIZE];

  always_ff @(posedge clk) begin
    if (a_en) begin
      if (a_we) begin
        for (int unsigned i = 0; i < NL; i++) begin
          if (a_sel[i]) begin
            mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
          end
        end
      end else begin
        a_rdata <= mem[a_addr];
      end
    end
    if (b_en) begin
      b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/mem_window.sv
// mem_window: address-decoded memory window on the system bus with an
// internal dual-port RAM and a read-only side port (video/text fetch).
// Pipeline: D (registered decode) -> M (RAM access) -> [output reg if LAT=2].
// b_rdata is zero except in the ack cycle of a read, so windows can be OR-ed.
// Optional macro MEM_WINDOW_FWD_EN: side read colliding with an M-stage bus
// write returns the lane-merged word instead of the old RAM word.
// Ports:
//   clk, reset_n         clock, async active-low reset
//   b_req, b_we          bus request / write (1) or read (0)
//   b_addr [AW]          bus word address
//   b_sel [DW/8]         write byte-lane enables
//   b_wdata / b_rdata    bus write / read data
//   b_ack                one-cycle ack for window hits, LAT cycles after decode
//   s_en, s_addr         side read enable and word offset
//   s_rdata              side read data, 1-cycle latency, held while s_en=0

module mem_window
  import mem_window_pkg::*;
#(
  parameter  longint unsigned BASE = 0,
  parameter  int unsigned     SIZE = 1024,
  parameter  int unsigned     DW   = 32,
  parameter  int unsigned     AW   = 32,
  parameter  int unsigned     LAT  = 1,
  localparam int unsigned     OW   = mw_clog2(SIZE),
  localparam int unsigned     NL   = `MEM_WINDOW_LANES(DW)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [NL-1:0] b_sel,
  input  logic [DW-1:0] b_wdata,
  output logic [DW-1:0] b_rdata,
  output logic          b_ack,
  input  logic          s_en,
  input  logic [OW-1:0] s_addr,
  output logic [DW-1:0] s_rdata
);

  // Window bounds in AW+1 bits so BASE+SIZE = 2^AW stays representable.
  localparam logic [AW:0]   WIN_LO   = (AW+1)'(BASE);
  localparam logic [AW:0]   WIN_HI   = WIN_LO + (AW+1)'(SIZE);
  localparam logic [OW-1:0] BASE_OFF = OW'(BASE);

  logic [AW:0] addr_x;
  logic        hit;

  assign addr_x = {1'b0, b_addr};
  assign hit    = b_req && (addr_x >= WIN_LO) && (addr_x < WIN_HI);

  // ---------------- Stage D ----------------
  logic          d_vld;
  logic          d_we;
  logic [OW-1:0] d_off;
  logic [NL-1:0] d_sel;
  logic [DW-1:0] d_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_vld <= 1'b0;
    end else begin
      d_vld <= hit;
    end
  end

  // Offset only needs the low bits: the window is SIZE-aligned in offset space.
  always_ff @(posedge clk) begin
    if (hit) begin
      d_we    <= b_we;
      d_off   <= b_addr[OW-1:0] - BASE_OFF;
      d_sel   <= b_sel;
      d_wdata <= b_wdata;
    end
  end

  // ---------------- Stage M ----------------
  logic          m_vld;
  logic          m_rd;
  logic [DW-1:0] ram_qa;
  logic [DW-1:0] ram_qb;

  mem_window_ram #(
    .SIZE (SIZE),
    .DW   (DW)
  ) u_ram (
    .clk     (clk),
    .a_en    (d_vld),
    .a_we    (d_we),
    .a_sel   (d_sel),
    .a_addr  (d_off),
    .a_wdata (d_wdata),
    .a_rdata (ram_qa),
    .b_en    (s_en),
    .b_addr  (s_addr),
    .b_rdata (ram_qb)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_vld <= 1'b0;
      m_rd  <= 1'b0;
    end else begin
      m_vld <= d_vld;
      m_rd  <= d_vld && !d_we;
    end
  end

  // ---------------- Ack / read data ----------------
  if (LAT > LAT_MIN) begin : g_lat2
    logic          o_vld;
    logic [DW-1:0] o_data;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        o_vld  <= 1'b0;
        o_data <= '0;
      end else begin
        o_vld  <= m_vld;
        o_data <= m_rd ? ram_qa : '0;
      end
    end

    assign b_ack   = o_vld;
    assign b_rdata = o_data;
  end else begin : g_lat1
    assign b_ack   = m_vld;
    assign b_rdata = m_rd ? ram_qa : '0;
  end

  // ---------------- Side port ----------------
  // RAM output register has no reset; s_vld masks it to zero until the first
  // side read after reset.
  logic s_vld;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_vld <= 1'b0;
    end else if (s_en) begin
      s_vld <= 1'b1;
    end
  end

`ifdef MEM_WINDOW_FWD_EN
  // Collision info is captured alongside the RAM read so it holds with s_rdata.
  logic          f_hit;
  logic [NL-1:0] f_sel;
  logic [DW-1:0] f_data;
  logic [DW-1:0] s_word;

  always_ff @(posedge clk) begin
    if (s_en) begin
      f_hit  <= d_vld && d_we && (d_off == s_addr);
      f_sel  <= d_sel;
      f_data <= d_wdata;
    end
  end

  always_comb begin
    s_word = ram_qb;
    if (f_hit) begin
      for (int unsigned i = 0; i < NL; i++) begin
        if (f_sel[i]) begin
          s_word[i*8 +: 8] = f_data[i*8 +: 8];
        end
      end
    end
  end

  assign s_rdata = s_vld ? s_word : '0;
`else
  assign s_rdata = s_vld ? ram_qb : '0;
`endif

endmodule

// File: tb/tb_mem_window.sv
// tb_mem_window: two windows (A: AW=32 BASE=0x100 LAT=1; B: AW=16 BASE=0xFC00
// LAT=2, top of address space) driven by directed and random traffic and
// compared every cycle against a transaction-level model of the window.

module tb_mem_window;

  localparam int unsigned     SZ     = 1024;
  localparam longint unsigned BASE_A = 64'h100;
  localparam longint unsigned BASE_B = 64'hFC00;
  localparam int unsigned     LAT_A  = 1;
  localparam int unsigned     LAT_B  = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_a, we_a, ack_a, sen_a;
  logic [31:0] addr_a, wd_a, rd_a, srd_a;
  logic [3:0]  sel_a;
  logic [9:0]  saddr_a;

  logic        req_b, we_b, ack_b, sen_b;
  logic [15:0] addr_b;
  logic [31:0] wd_b, rd_b, srd_b;
  logic [3:0]  sel_b;
  logic [9:0]  saddr_b;

  mem_window #(.BASE(BASE_A), .SIZE(SZ), .DW(32), .AW(32), .LAT(LAT_A)) u_a (
    .clk(clk), .reset_n(reset_n), .b_req(req_a), .b_we(we_a), .b_addr(addr_a),
    .b_sel(sel_a), .b_wdata(wd_a), .b_rdata(rd_a), .b_ack(ack_a),
    .s_en(sen_a), .s_addr(saddr_a), .s_rdata(srd_a)
  );

  mem_window #(.BASE(BASE_B), .SIZE(SZ), .DW(32), .AW(16), .LAT(LAT_B)) u_b (
    .clk(clk), .reset_n(reset_n), .b_req(req_b), .b_we(we_b), .b_addr(addr_b),
    .b_sel(sel_b), .b_wdata(wd_b), .b_rdata(rd_b), .b_ack(ack_b),
    .s_en(sen_b), .s_addr(saddr_b), .s_rdata(srd_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- Reference model ----------------
  logic [31:0]     mmem   [2][SZ];
  bit              pv     [2];
  bit              pwe    [2];
  int unsigned     poff   [2];
  logic [3:0]      psel   [2];
  logic [31:0]     pwd    [2];
  bit              ack_at [2][8];
  logic [31:0]     dat_at [2][8];
  logic [31:0]     exp_s  [2];
  bit              exp_ack[2];
  logic [31:0]     exp_rd [2];
  longint unsigned cyc = 0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] mask;
    mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    return (old & ~mask) | (nw & mask);
  endfunction

  // One clock edge of one window: the op issued on the previous edge is
  // performed now (side read sees memory before that write), then the new
  // request is decoded, then the expected outputs for this cycle are taken.
  task automatic model_step(input int id, input longint unsigned base, input int unsigned lat,
                            input bit req, input bit we, input longint unsigned addr,
                            input logic [3:0] sel, input logic [31:0] wd,
                            input bit sen, input int unsigned saddr);
    int unsigned slot;
    if (!reset_n) begin
      pv[id] = 0;
      for (int k = 0; k < 8; k++) begin
        ack_at[id][k] = 0;
        dat_at[id][k] = '0;
      end
      exp_s[id]   = '0;
      exp_ack[id] = 0;
      exp_rd[id]  = '0;
      return;
    end
    if (sen) begin
      exp_s[id] = mmem[id][saddr];
`ifdef MEM_WINDOW_FWD_EN
      if (pv[id] && pwe[id] && poff[id] == saddr)
        exp_s[id] = merge(mmem[id][saddr], pwd[id], psel[id]);
`endif
    end
    if (pv[id]) begin
      slot = int'((cyc + lat - 1) % 8);
      ack_at[id][slot] = 1;
      if (pwe[id]) begin
        mmem[id][poff[id]] = merge(mmem[id][poff[id]], pwd[id], psel[id]);
        dat_at[id][slot] = '0;
      end else begin
        dat_at[id][slot] = mmem[id][poff[id]];
      end
    end
    pv[id] = req && (addr >= base) && (addr < base + SZ);
    if (pv[id]) begin
      pwe[id]  = we;
      poff[id] = int'(addr - base);
      psel[id] = sel;
      pwd[id]  = wd;
    end
    slot = int'(cyc % 8);
    exp_ack[id] = ack_at[id][slot];
    exp_rd[id]  = dat_at[id][slot];
    ack_at[id][slot] = 0;
    dat_at[id][slot] = '0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < int'(SZ); j++) mmem[i][j] = '0;
    end
  end

  always begin
    @(posedge clk);
    model_step(0, BASE_A, LAT_A, req_a, we_a, longint'(addr_a), sel_a, wd_a, sen_a, int'(saddr_a));
    model_step(1, BASE_B, LAT_B, req_b, we_b, longint'(addr_b), sel_b, wd_b, sen_b, int'(saddr_b));
    cyc++;
    #1;
    check("m_ack_a", 32'(ack_a), 32'(exp_ack[0]));
    check("m_rd_a", rd_a, exp_rd[0]);
    check("m_srd_a", srd_a, exp_s[0]);
    check("m_ack_b", 32'(ack_b), 32'(exp_ack[1]));
    check("m_rd_b", rd_b, exp_rd[1]);
    check("m_srd_b", srd_b, exp_s[1]);
  end

  // ---------------- Drivers ----------------
  task automatic bus(input int id, input bit we, input longint unsigned addr,
                     input logic [3:0] sel, input logic [31:0] wd);
    if (id == 0) begin
      req_a = 1'b1; we_a = we; addr_a = addr[31:0]; sel_a = sel; wd_a = wd;
    end else begin
      req_b = 1'b1; we_b = we; addr_b = addr[15:0]; sel_b = sel; wd_b = wd;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_a = 1'b0; req_b = 1'b0; sen_a = 1'b0; sen_b = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  bit          ackv [13];
  logic [31:0] rdv  [13];
  logic [31:0] pw   [4];
  logic [31:0] prev_a;
  logic [15:0] prev_b;

  initial begin
    req_a = 0; we_a = 0; addr_a = '0; sel_a = '0; wd_a = '0; sen_a = 0; saddr_a = '0;
    req_b = 0; we_b = 0; addr_b = '0; sel_b = '0; wd_b = '0; sen_b = 0; saddr_b = '0;
    repeat (3) @(negedge clk);
    check("rst_ack_a", 32'(ack_a), 32'd0);
    check("rst_rd_a", rd_a, 32'd0);
    check("rst_srd_a", srd_a, 32'd0);
    check("rst_ack_b", 32'(ack_b), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Preload both windows with zeros.
    for (int i = 0; i < int'(SZ); i++) begin
      req_a = 1; we_a = 1; addr_a = 32'(BASE_A) + 32'(i); sel_a = 4'hF; wd_a = '0;
      req_b = 1; we_b = 1; addr_b = 16'(BASE_B) + 16'(i); sel_b = 4'hF; wd_b = '0;
      @(negedge clk);
    end
    idle(3);

    // Range edges, window A (LAT=1).
    bus(0, 0, 64'h0FF, 4'h0, '0); idle(1);
    check("edge_lo_ack", 32'(ack_a), 32'd0);
    check("edge_lo_rd", rd_a, 32'd0);
    bus(0, 0, 64'h4FF, 4'h0, '0); idle(1);
    check("edge_top_ack", 32'(ack_a), 32'd1);
    bus(0, 0, 64'h500, 4'h0, '0); idle(1);
    check("edge_hi_ack", 32'(ack_a), 32'd0);

    // Byte lanes with back-to-back read-after-write.
    bus(0, 1, 64'h104, 4'hF, 32'hAABBCCDD);
    bus(0, 1, 64'h104, 4'b0101, 32'h11223344);
    bus(0, 0, 64'h104, 4'h0, '0);
    idle(1);
    check("lanes_ack", 32'(ack_a), 32'd1);
    check("lanes_rd", rd_a, 32'hAA22CC44);
    idle(2);

    // Pipelining, window B (LAT=2): 4 writes then 4 reads back-to-back.
    for (int i = 0; i < 4; i++) pw[i] = $urandom;
    fork
      begin
        for (int i = 0; i < 4; i++) bus(1, 1, BASE_B + longint'(i), 4'hF, pw[i]);
        for (int i = 0; i < 4; i++) bus(1, 0, BASE_B + longint'(i), 4'h0, '0);
        idle(1);
      end
      begin
        for (int k = 1; k <= 12; k++) begin
          @(negedge clk);
          ackv[k] = ack_b;
          rdv[k]  = rd_b;
        end
      end
    join
    for (int k = 1; k <= 12; k++) check("pipe_ack", 32'(ackv[k]), 32'((k >= 3) && (k <= 10)));
    for (int k = 7; k <= 10; k++) check("pipe_rd", rdv[k], pw[k-7]);

    // Top of address space, window B.
    bus(1, 0, 64'hFFFF, 4'h0, '0); idle(2);
    check("top_ack", 32'(ack_b), 32'd1);
    bus(1, 0, 64'hFBFF, 4'h0, '0); idle(2);
    check("below_ack", 32'(ack_b), 32'd0);
    check("below_rd", rd_b, 32'd0);

    // Side collision: write offset 5 in M while side reads offset 5.
    bus(0, 1, 64'h105, 4'hF, 32'hDEADBEEF);
    req_a = 1'b0; sen_a = 1'b1; saddr_a = 10'd5;
    @(negedge clk);
    sen_a = 1'b0;
`ifdef MEM_WINDOW_FWD_EN
    check("coll_srd", srd_a, 32'hDEADBEEF);
    @(negedge clk);
    check("coll_hold", srd_a, 32'hDEADBEEF);
`else
    check("coll_srd", srd_a, 32'd0);
    @(negedge clk);
    check("coll_hold", srd_a, 32'd0);
`endif
    sen_a = 1'b1; saddr_a = 10'd5;
    @(negedge clk);
    sen_a = 1'b0;
    check("coll_after", srd_a, 32'hDEADBEEF);

    // Reset in the middle of a read.
    sen_a = 1'b1; saddr_a = 10'd4;
    @(negedge clk);
    sen_a = 1'b0;
    check("pre_rst_srd", srd_a, 32'hAA22CC44);
    bus(0, 0, 64'h100, 4'h0, '0);
    req_a = 1'b0;
    reset_n = 1'b0;
    #1;
    check("mid_rst_rd", rd_a, 32'd0);
    check("mid_rst_srd", srd_a, 32'd0);
    check("mid_rst_ack", 32'(ack_a), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_ack", 32'(ack_a), 32'd0);
    end

    // Random traffic around the window edges on both windows.
    prev_a = 32'h100;
    prev_b = 16'hFC00;
    for (int n = 0; n < 800; n++) begin
      req_a = ($urandom_range(0, 3) != 0);
      we_a  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       addr_a = $urandom;
        1:       addr_a = 32'h100 + SZ - 2 + $urandom_range(0, 3);
        2:       addr_a = 32'h0FE + $urandom_range(0, 3);
        default: addr_a = 32'h100 + $urandom_range(0, 15);
      endcase
      sel_a   = 4'($urandom);
      wd_a    = $urandom;
      sen_a   = 1'($urandom_range(0, 1));
      saddr_a = ($urandom_range(0, 1) != 0) ? 10'(prev_a - 32'h100) : 10'($urandom);
      prev_a  = addr_a;

      req_b = ($urandom_range(0, 3) != 0);
      we_b  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       addr_b = 16'($urandom);
        1:       addr_b = 16'(32'hFFFC + $urandom_range(0, 7));
        2:       addr_b = 16'(32'hFBFE + $urandom_range(0, 3));
        default: addr_b = 16'(32'hFC00 + $urandom_range(0, 15));
      endcase
      sel_b   = 4'($urandom);
      wd_b    = $urandom;
      sen_b   = 1'($urandom_range(0, 1));
      saddr_b = ($urandom_range(0, 1) != 0) ? 10'(prev_b - 16'hFC00) : 10'($urandom);
      prev_b  = addr_b;
      @(negedge clk);
    end
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
